immediate_decode_stage: RTL
===========================

# immediate_decode_stage

Buffered, parametrised immediate decode stage between instruction fetch and the execute datapath. Each accepted instruction is classified by opcode, its immediate is extracted and sign- or zero-extended to XLEN, and illegal opcodes are flagged. The result is queued with the instruction and PC in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It supports RV32/RV64 widths, RV64 word opcodes and CSR zero-extended immediates, none of which the single-cycle combinational generator handles.

## Interface

Parameters:

- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- ENABLE_ZICSR, 1, when 1, the CSR-immediate format is decoded; when 0, all SYSTEM opcodes are I-type.

Ports:

- clock, input, 1, single clock; all state is updated on the rising edge.
- reset_n, input, 1, reset; asynchronous assert, active-low.
- in_valid, input, 1, an upstream instruction is offered.
- in_ready, output, 1, the stage accepts this cycle; equals !full.
- instruction, input, 32, raw instruction word.
- pc, input, XLEN, address of the instruction.
- out_valid, output, 1, the head entry is valid; equals !empty.
- out_ready, input, 1, downstream consumes the head entry.
- out_instruction, output, 32, head instruction.
- out_pc, output, XLEN, head PC.
- immediate, output, XLEN, decoded immediate of the head entry.
- format, output, 3, head format: R=0, I=1, S=2, B=3, U=4, J=5, CSR_IMM=6.
- illegal, output, 1, head opcode is unrecognised.
- count, output, $clog2(DEPTH)+1, current occupancy.

## Operation

Decode is combinational on the input side and is written into the FIFO on a push.

Opcode to format mapping:

- 0000011, 0010011, 1100111 (LOAD, OP-IMM, JALR) -> I.
- 0100011 (STORE) -> S.
- 1100011 (BRANCH) -> B.
- 0010111, 0110111 (AUIPC, LUI) -> U.
- 1101111 (JAL) -> J.
- 0110011 (OP) -> R.
- 0001111 (FENCE) -> I.
- 1110011 (SYSTEM) -> CSR_IMM if ENABLE_ZICSR=1 and instruction[14]=1; otherwise I.
- XLEN=64 only: 0011011 (OP-IMM-32) -> I; 0111011 (OP-32) -> R.
- Any other opcode, including any word with [1:0] != 2'b11 -> R with illegal=1.

Immediate extraction (sign extension is from the top bit to XLEN):

- I: sext(inst[31:20]).
- S: sext({inst[31:25], inst[11:7]}).
- B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); bit 0 is always 0.
- U: sext({inst[31:12], 12'b0}).
- J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- CSR_IMM: zero-extended inst[19:15].
- R and illegal: 0.

FIFO behaviour:

- push = in_valid & in_ready; pop = out_valid & out_ready.
- Circular buffer with read and write pointers that wrap modulo DEPTH.
- count increments on push only and decrements on pop only; it is unchanged on simultaneous push and pop.
- in_ready depends only on count (no combinational path from out_ready).
- Full (count=DEPTH): in_ready=0, in_valid is ignored, and a pop in the same cycle does not admit a push.
- Empty: out_valid=0 and out_ready is ignored.
- All payload outputs (out_instruction, out_pc, immediate, format, illegal) are forced to 0 while empty.
- Order is strictly FIFO.

## Timing

- Reset (reset_n=0, asynchronous): count=0, pointers=0, out_valid=0, in_ready=1, all payload outputs 0; storage contents are don't-care.
- Reset asserted mid-operation discards every queued entry immediately, without waiting for a clock edge. The first push is accepted on the first rising edge after reset_n rises.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N; it can be popped at edge N+1 at the earliest. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.

## Test plan

- XLEN=32: push 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_valid=1, format=1, immediate=0xFFFFFFFF, illegal=0.
- Push 0xFE000EE3 (beq x0,x0,-4) -> format=3, immediate=0xFFFFFFFC. Push 0x3002D073 (csrrwi, ENABLE_ZICSR=1) -> format=6, immediate=0x00000005. Repeat the csrrwi push with ENABLE_ZICSR=0 -> format=1, immediate=0x00000300.
- XLEN=64: push 0x800000B7 (lui) -> format=4, immediate=0xFFFFFFFF80000000. Push opcode 0011011 with inst[31:20]=0x800 -> format=1, immediate=0xFFFFFFFFFFFFF800.
- Push 0x00000000 -> illegal=1, format=0, immediate=0. With XLEN=32, push opcode 0011011 -> illegal=1.
- DEPTH=4, out_ready=0, in_valid=1 for 6 cycles -> in_ready falls after 4 pushes and count=4. Then set out_ready=1 with in_valid=1 -> entries leave in push order, one per cycle; no push is accepted in the cycle the FIFO was full, and count never exceeds 4.
- Push 2 entries (count=2), then pull reset_n low between clock edges -> out_valid and count drop to 0 without waiting for an edge. After release, one push -> out_valid=1 one cycle later with the new data only.

Source files
------------

// File: rtl/immediate_decode_stage.sv
// immediate_decode_stage: classifies each instruction, extracts its
// immediate and queues it with instr/PC in a DEPTH-entry FIFO.
// Ports:
//   clock, reset_n                           clock, async active-low reset
//   in_valid/in_ready, instruction, pc       upstream handshake + payload
//   out_valid/out_ready                      downstream handshake
//   out_instruction, out_pc, immediate,      head entry payload
//   format, illegal                          (all zero while empty)
//   count                                    current occupancy
module immediate_decode_stage #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int ENABLE_ZICSR = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instruction,
  input  logic [XLEN-1:0]            pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instruction,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            immediate,
  output logic [2:0]                 format,
  output logic                       illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] F_R   = 3'd0;
  localparam logic [2:0] F_I   = 3'd1;
  localparam logic [2:0] F_S   = 3'd2;
  localparam logic [2:0] F_B   = 3'd3;
  localparam logic [2:0] F_U   = 3'd4;
  localparam logic [2:0] F_J   = 3'd5;
  localparam logic [2:0] F_CSR = 3'd6;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  logic [31:0]     i;
  logic [2:0]      fmt_d;
  logic            ill_d;
  logic [63:0]     imm64;
  logic            unused_hi;
  ent_t            ent_in;
  ent_t            head;
  ent_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  assign i = instruction;

  always_comb begin
    fmt_d = F_R;
    ill_d = 1'b0;
    case (i[6:0])
      7'b0000011,
      7'b0010011,
      7'b1100111,
      7'b0001111: fmt_d = F_I;
      7'b0100011: fmt_d = F_S;
      7'b1100011: fmt_d = F_B;
      7'b0010111,
      7'b0110111: fmt_d = F_U;
      7'b1101111: fmt_d = F_J;
      7'b0110011: fmt_d = F_R;
      7'b1110011: begin
        if (ENABLE_ZICSR != 0 && i[14])
          fmt_d = F_CSR;
        else
          fmt_d = F_I;
      end
      7'b0011011: begin
        if (XLEN == 64) fmt_d = F_I;
        else ill_d = 1'b1;
      end
      7'b0111011: begin
        if (XLEN == 64) fmt_d = F_R;
        else ill_d = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
  end

  // Built at 64 bits, then narrowed, so one
  // table serves both RV32 and RV64.
  always_comb begin
    imm64 = '0;
    case (fmt_d)
      F_I: imm64 = {{52{i[31]}}, i[31:20]};
      F_S: imm64 = {{52{i[31]}}, i[31:25],
                    i[11:7]};
      F_B: imm64 = {{51{i[31]}}, i[31], i[7],
                    i[30:25], i[11:8], 1'b0};
      F_U: imm64 = {{32{i[31]}}, i[31:12],
                    12'b0};
      F_J: imm64 = {{43{i[31]}}, i[31],
                    i[19:12], i[20],
                    i[30:21], 1'b0};
      F_CSR: imm64 = {59'b0, i[19:15]};
      default: imm64 = '0;
    endcase
  end

  assign unused_hi = ^imm64;

  assign ent_in.inst = i;
  assign ent_in.pc   = pc;
  assign ent_in.imm  = imm64[XLEN-1:0];
  assign ent_in.fmt  = fmt_d;
  assign ent_in.ill  = ill_d;

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only
  // observable through a nonzero count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= ent_in;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_instruction = head.inst;
  assign out_pc          = head.pc;
  assign immediate       = head.imm;
  assign format          = head.fmt;
  assign illegal         = head.ill;

endmodule
